vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA/DVI raster timing generator with a pixel-request lookahead interface. It supersedes the fixed 640x480 controller. Porch/sync lengths, sync polarities, colour width and source fetch latency are all parameters. The block issues pixel coordinates ahead of time to a frame-buffer or pattern source, then re-aligns the returned colour with delayed sync/DE so the DAC/encoder sees a coherent raster.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FRONT / H_SYNC / H_BACK, 16 / 96 / 48, horizontal porch and pulse lengths (clocks, each ≥1)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT / V_SYNC / V_BACK, 10 / 2 / 33, vertical porch and pulse lengths (lines, each ≥1)
- H_POL / V_POL, 0 / 0, active level of oHSync / oVSync
- LAT, 2, source latency in clocks from oReq to valid iR/iG/iB (0..15)
- CW, 8, colour channel width
- XW, 12, coordinate/counter width; must hold H_TOTAL-1 and V_TOTAL-1
- iClk  in  1  pixel clock
- iRst  in  1  reset. One clock; reset is synchronous and active-high.
- oReq  out  1  pixel request: current position is visible
- oReqX / oReqY  out  XW  requested pixel coordinates
- iR / iG / iB  in  CW  source colour, valid LAT clocks after the matching oReq
- oR / oG / oB  out  CW  output colour, 0 outside active area
- oHSync / oVSync  out  1  sync pulses at configured polarity
- oDE  out  1  data enable (active pixel on output)
- oFrameStart  out  1  one-clock pulse with output pixel (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise.
- Counter origin is the first active pixel. Per line the order is active, front, sync, back. Frame order is the same.
- Stage 0: hcnt wraps at H_TOTAL-1. vcnt increments when hcnt wraps and itself wraps at V_TOTAL-1.
- oReq = !iRst && hcnt<H_ACTIVE && vcnt<V_ACTIVE. oReqX = hcnt, oReqY = vcnt, driven straight from the counter registers.
- hs0 is active when hcnt ∈ [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC). vs0 is active when vcnt ∈ [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC). vs0 changes only at hcnt==0.
- fs0 = oReq && hcnt==0 && vcnt==0.
- hs0/vs0/de0/fs0 pass through a LAT-deep shift register and then one output register.
- The output register samples iR/iG/iB when the delayed de is 1; otherwise it loads 0.
- Counter widths are compared at XW bits; no arithmetic overflow is possible given the XW constraint.

## Timing
- Total latency from oReq (cycle t) to oDE/oR/oG/oB (cycle t+LAT+1). The colour is captured from iR/iG/iB at cycle t+LAT.
- Sync and oFrameStart share the same LAT+1 delay, so sync timing relative to oDE equals the parameterised timing exactly.
- While iRst=1: counters=0, delay line cleared to inactive, oReq=0, oR/oG/oB=0, oDE=0, oFrameStart=0, oHSync=!H_POL, oVSync=!V_POL.
- First clock after iRst falls: oReq=1, oReqX=0, oReqY=0. The first oDE and oFrameStart occur LAT+1 clocks later.
- Reset asserted mid-frame takes effect on the next edge. There are no partial pulses beyond the outputs already registered, and the in-flight delay line is discarded.
- Wrap at (H_TOTAL-1, V_TOTAL-1) returns to (0,0) on the next clock with no idle gap.
- Line period is H_TOTAL clocks; frame period is H_TOTAL*V_TOTAL clocks.

## Configuration
- VGA_TIMING_GEN_PATTERN_EN defined:
  - Adds input iPatternSel (1 bit).
  - When high, the colour captured by the output stage comes from an internal 8-bar generator instead of iR/iG/iB.
  - A bar sub-counter advances bar b every H_ACTIVE/8 active pixels; H_ACTIVE must be divisible by 8.
  - b resets at hcnt==0.
  - Channel colours are all-ones or 0: R when b∈{0,1,4,5}, G when b∈{0,1,2,3}, B when b∈{0,2,4,6}.
  - The pattern is computed at stage 0 and delayed LAT clocks, so it aligns exactly like source data.
  - iPatternSel is sampled at stage 0.
- Macro undefined: no iPatternSel port and no pattern logic; colour is always taken from iR/iG/iB.

## Test plan
- Defaults, LAT=2: after reset release, the first oDE is at clock 3. oHSync is low for 96 clocks starting at clock 3+656. Line period is 800, frame period is 420000.
- Small params (H 4/1/2/1, V 3/1/1/1, LAT=0): oReqX sequence is 0..7 repeating. oReq is high for X<4 and Y<3. oVSync is low for 8 clocks per 48-clock frame.
- LAT=3, source returns iR=oReqX[7:0] delayed 3 clocks: oR equals the output pixel x on every oDE clock, and 0 when oDE=0.
- H_POL=1, V_POL=1: sync pulses are high-active with identical positions; reset level is 0 on both.
- iRst asserted for 1 clock mid-line at hcnt=300: outputs reach their reset values next clock. Restart gives oReqX=0, oReqY=0, and oFrameStart fires LAT+1 clocks later.
- VGA_TIMING_GEN_PATTERN_EN with iPatternSel=1 at defaults: output pixels 0..79 are white (FF,FF,FF), 80..159 yellow (FF,FF,00), and 560..639 black.

Source files
------------

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA/DVI raster timing generator with pixel-request lookahead
//
// Optional feature macro: VGA_TIMING_GEN_PATTERN_EN adds iPatternSel and an
// internal 8-bar colour pattern that can replace the source colour.
//
// Ports:
//   iClk         in   pixel clock
//   iRst         in   synchronous active-high reset
//   iPatternSel  in   (VGA_TIMING_GEN_PATTERN_EN only) select internal bar pattern
//   oReq         out  current counter position is visible; source must answer in LAT clocks
//   oReqX/oReqY  out  requested pixel coordinates (raw counter values)
//   iR/iG/iB     in   source colour, valid LAT clocks after the matching oReq
//   oR/oG/oB     out  output colour, 0 outside the active area
//   oHSync       out  horizontal sync at polarity H_POL
//   oVSync       out  vertical sync at polarity V_POL
//   oDE          out  data enable aligned with oR/oG/oB
//   oFrameStart  out  one-clock pulse with output pixel (0,0)

module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FRONT  = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BACK   = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FRONT  = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BACK   = 33,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b0,
    parameter int   LAT      = 2,
    parameter int   CW       = 8,
    parameter int   XW       = 12
) (
    input  logic          iClk,
    input  logic          iRst,
`ifdef VGA_TIMING_GEN_PATTERN_EN
    input  logic          iPatternSel,
`endif
    output logic          oReq,
    output logic [XW-1:0] oReqX,
    output logic [XW-1:0] oReqY,
    input  logic [CW-1:0] iR,
    input  logic [CW-1:0] iG,
    input  logic [CW-1:0] iB,
    output logic [CW-1:0] oR,
    output logic [CW-1:0] oG,
    output logic [CW-1:0] oB,
    output logic          oHSync,
    output logic          oVSync,
    output logic          oDE,
    output logic          oFrameStart
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [XW-1:0] H_LAST     = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] V_LAST     = XW'(V_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT_END  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] V_ACT_END  = XW'(V_ACTIVE);
    localparam logic [XW-1:0] HS_START   = XW'(H_ACTIVE + H_FRONT);
    localparam logic [XW-1:0] HS_END     = XW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [XW-1:0] VS_START   = XW'(V_ACTIVE + V_FRONT);
    localparam logic [XW-1:0] VS_END     = XW'(V_ACTIVE + V_FRONT + V_SYNC);

    // Delay-line word: {frameStart, de, vsActive, hsActive} plus, with the
    // pattern option, {patternSel, barR, barG, barB}. Sync bits are carried as
    // "active" flags so a cleared line means inactive regardless of polarity.
`ifdef VGA_TIMING_GEN_PATTERN_EN
    localparam int PW = 4;
`else
    localparam int PW = 0;
`endif
    localparam int DW = 4 + PW;

    // ------------------------------------------------------------------
    // Stage 0: raster counters
    // ------------------------------------------------------------------
    logic [XW-1:0] hCnt;
    logic [XW-1:0] vCnt;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            hCnt <= '0;
            vCnt <= '0;
        end else if (hCnt == H_LAST) begin
            hCnt <= '0;
            vCnt <= (vCnt == V_LAST) ? '0 : vCnt + 1'b1;
        end else begin
            hCnt <= hCnt + 1'b1;
        end
    end

    logic hActive;
    logic vActive;
    logic hs0;
    logic vs0;
    logic fs0;

    always_comb begin
        hActive = (hCnt < H_ACT_END);
        vActive = (vCnt < V_ACT_END);
        oReq    = !iRst && hActive && vActive;
        hs0     = (hCnt >= HS_START) && (hCnt < HS_END);
        // vCnt only moves on the hCnt wrap, so vs0 only changes at hCnt==0.
        vs0     = (vCnt >= VS_START) && (vCnt < VS_END);
        fs0     = oReq && (hCnt == '0) && (vCnt == '0);
    end

    assign oReqX = hCnt;
    assign oReqY = vCnt;

    logic [DW-1:0] stage0Word;

`ifdef VGA_TIMING_GEN_PATTERN_EN
    // ------------------------------------------------------------------
    // Stage 0: 8-bar pattern. barSub counts pixels within a bar; barIdx
    // selects the bar and restarts at the beginning of every line.
    // ------------------------------------------------------------------
    localparam int            BAR_LEN     = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam logic [XW-1:0] BAR_SUB_MAX = XW'(BAR_LEN - 1);

    logic [XW-1:0] barSub;
    logic [2:0]    barIdx;

    always_ff @(posedge iClk) begin
        if (iRst || hCnt == H_LAST) begin
            barSub <= '0;
            barIdx <= '0;
        end else if (hActive) begin
            if (barSub == BAR_SUB_MAX) begin
                barSub <= '0;
                barIdx <= barIdx + 3'd1;
            end else begin
                barSub <= barSub + 1'b1;
            end
        end
    end

    // Bars 0..7: white, yellow, cyan, green, magenta, red, blue, black.
    logic barR;
    logic barG;
    logic barB;

    always_comb begin
        barR       = !barIdx[1];
        barG       = !barIdx[2];
        barB       = !barIdx[0];
        stage0Word = {iPatternSel, barR, barG, barB, fs0, oReq, vs0, hs0};
    end
`else
    assign stage0Word = {fs0, oReq, vs0, hs0};
`endif

    // ------------------------------------------------------------------
    // LAT-deep delay line, cleared by reset so in-flight pixels are dropped.
    // ------------------------------------------------------------------
    logic [DW-1:0] stageD;

    generate
        if (LAT == 0) begin : gNoDelay
            assign stageD = stage0Word;
        end else begin : gDelay
            logic [DW-1:0] pipe [LAT];

            always_ff @(posedge iClk) begin
                if (iRst) begin
                    for (int i = 0; i < LAT; i++) begin
                        pipe[i] <= '0;
                    end
                end else begin
                    pipe[0] <= stage0Word;
                    for (int i = 1; i < LAT; i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end

            assign stageD = pipe[LAT-1];
        end
    endgenerate

    logic hsD;
    logic vsD;
    logic deD;
    logic fsD;
    logic [CW-1:0] pixR;
    logic [CW-1:0] pixG;
    logic [CW-1:0] pixB;

    always_comb begin
        hsD  = stageD[0];
        vsD  = stageD[1];
        deD  = stageD[2];
        fsD  = stageD[3];
        pixR = iR;
        pixG = iG;
        pixB = iB;
`ifdef VGA_TIMING_GEN_PATTERN_EN
        if (stageD[7]) begin
            pixR = {CW{stageD[6]}};
            pixG = {CW{stageD[5]}};
            pixB = {CW{stageD[4]}};
        end
`endif
    end

    // ------------------------------------------------------------------
    // Output register: colour captured only while the delayed DE is set.
    // ------------------------------------------------------------------
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oR          <= '0;
            oG          <= '0;
            oB          <= '0;
            oDE         <= 1'b0;
            oFrameStart <= 1'b0;
            oHSync      <= !H_POL;
            oVSync      <= !V_POL;
        end else begin
            oDE         <= deD;
            oFrameStart <= fsD;
            oHSync      <= hsD ? H_POL : !H_POL;
            oVSync      <= vsD ? V_POL : !V_POL;
            if (deD) begin
                oR <= pixR;
                oG <= pixG;
                oB <= pixB;
            end else begin
                oR <= '0;
                oG <= '0;
                oB <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized self-checking bench for vga_timing_gen

module tb_vga_timing_gen;

    localparam int   HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int   VA = 5,  VF = 1, VS = 2, VB = 1;
    localparam int   LAT = 3, CW = 8, XW = 6;
    localparam logic HPOL = 1'b1, VPOL = 1'b0;
    localparam int   HT = HA + HF + HS + HB;
    localparam int   VT = VA + VF + VS + VB;
    localparam int   NC = 2400;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] inR, inG, inB;
    logic          req;
    logic [XW-1:0] reqX, reqY;
    logic [CW-1:0] outR, outG, outB;
    logic          hSync, vSync, de, frameStart;
`ifdef VGA_TIMING_GEN_PATTERN_EN
    logic          patSel;
`endif

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_POL(HPOL), .V_POL(VPOL), .LAT(LAT), .CW(CW), .XW(XW)
    ) dut (
        .iClk(clk),
        .iRst(rst),
`ifdef VGA_TIMING_GEN_PATTERN_EN
        .iPatternSel(patSel),
`endif
        .oReq(req),
        .oReqX(reqX),
        .oReqY(reqY),
        .iR(inR),
        .iG(inG),
        .iB(inB),
        .oR(outR),
        .oG(outG),
        .oB(outB),
        .oHSync(hSync),
        .oVSync(vSync),
        .oDE(de),
        .oFrameStart(frameStart)
    );

    int nCmp = 0;
    int nBad = 0;
    int curCyc = 0;

    // Per-cycle history of stimulus and of the modelled raster position.
    bit            rstH   [NC];
    bit            selH   [NC];
    bit            validH [NC];
    int            posH   [NC];
    logic [CW-1:0] rH [NC];
    logic [CW-1:0] gH [NC];
    logic [CW-1:0] bH [NC];

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCmp++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, curCyc, got, exp);
        end
    endtask

    function automatic int xOf(input int k);
        return posH[k] % HT;
    endfunction

    function automatic int yOf(input int k);
        return (posH[k] / HT) % VT;
    endfunction

    function automatic bit deAt(input int k);
        return !rstH[k] && xOf(k) < HA && yOf(k) < VA;
    endfunction

    function automatic bit hsAt(input int k);
        return xOf(k) >= HA + HF && xOf(k) < HA + HF + HS;
    endfunction

    function automatic bit vsAt(input int k);
        return yOf(k) >= VA + VF && yOf(k) < VA + VF + VS;
    endfunction

    function automatic bit fsAt(input int k);
        return deAt(k) && xOf(k) == 0 && yOf(k) == 0;
    endfunction

    initial begin
        rst = 1'b1;
        inR = '0;
        inG = '0;
        inB = '0;
`ifdef VGA_TIMING_GEN_PATTERN_EN
        patSel = 1'b0;
`endif
        @(posedge clk);
        #1;
        for (int c = 0; c < NC; c++) begin
            int  k;
            bit  anyRst;
            bit  eDe, eHs, eVs, eFs;
            logic [CW-1:0] eR, eG, eB;

            curCyc  = c;
            rstH[c] = (c < 3) || (c == 1000) || ($urandom_range(0, 599) == 0);
            selH[c] = ($urandom_range(0, 3) != 0);
            rH[c]   = CW'($urandom);
            gH[c]   = CW'($urandom);
            bH[c]   = CW'($urandom);
            if (c == 0) begin
                validH[c] = 1'b0;
                posH[c]   = 0;
            end else begin
                validH[c] = validH[c-1] || rstH[c-1];
                posH[c]   = rstH[c-1] ? 0 : posH[c-1] + 1;
            end
            rst = rstH[c];
            inR = rH[c];
            inG = gH[c];
            inB = bH[c];
`ifdef VGA_TIMING_GEN_PATTERN_EN
            patSel = selH[c];
`endif
            @(negedge clk);

            if (validH[c]) begin
                checkEq("oReq",  32'(req),  32'(deAt(c)));
                checkEq("oReqX", 32'(reqX), 32'(xOf(c)));
                checkEq("oReqY", 32'(reqY), 32'(yOf(c)));
            end

            // Output in cycle c reflects stage 0 of cycle c-1-LAT unless a
            // reset edge occurred anywhere since then.
            k = c - 1 - LAT;
            anyRst = 1'b0;
            for (int j = (k < 0 ? 0 : k); j < c; j++) anyRst |= rstH[j];
            if (anyRst || (k >= 0 && validH[k])) begin
                if (anyRst) begin
                    eDe = 0; eHs = 0; eVs = 0; eFs = 0;
                    eR = '0; eG = '0; eB = '0;
                end else begin
                    eDe = deAt(k);
                    eHs = hsAt(k);
                    eVs = vsAt(k);
                    eFs = fsAt(k);
                    eR = '0; eG = '0; eB = '0;
                    if (eDe) begin
                        eR = rH[c-1];
                        eG = gH[c-1];
                        eB = bH[c-1];
`ifdef VGA_TIMING_GEN_PATTERN_EN
                        if (selH[k]) begin
                            int bar;
                            bar = xOf(k) / (HA / 8);
                            eR = (bar inside {0, 1, 4, 5}) ? '1 : '0;
                            eG = (bar inside {0, 1, 2, 3}) ? '1 : '0;
                            eB = (bar inside {0, 2, 4, 6}) ? '1 : '0;
                        end
`endif
                    end
                end
                checkEq("oDE",         32'(de),         32'(eDe));
                checkEq("oFrameStart", 32'(frameStart), 32'(eFs));
                checkEq("oHSync",      32'(hSync),      32'(eHs ? HPOL : !HPOL));
                checkEq("oVSync",      32'(vSync),      32'(eVs ? VPOL : !VPOL));
                checkEq("oR",          32'(outR),       32'(eR));
                checkEq("oG",          32'(outG),       32'(eG));
                checkEq("oB",          32'(outB),       32'(eB));
            end

            @(posedge clk);
            #1;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
